// File: rtl/bs_pkg.sv
// Shared definitions for the barrel-shifter output path: word width,
// serializer state encoding and a constant-foldable clog2.
package bs_pkg;

    localparam int BS_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bs_byte_fifo.sv
// Small synchronous first-word-fall-through FIFO holding shifted words
// until the serializer is ready to take them.
module bs_byte_fifo
    import bs_pkg::*;
#(
    parameter int WIDTH = BS_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [clog2(DEPTH):0]     count
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Guard against overflow/underflow so callers cannot corrupt the count.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/bs_out_serializer.sv
// Buffers barrel-shifter output words and emits them as a bit-serial
// stream with per-bit handshake and a last-bit marker.
module bs_out_serializer
    import bs_pkg::*;
#(
    parameter int WIDTH     = BS_WIDTH,
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int CNT_W = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;
    localparam int FCW   = clog2(DEPTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;
    logic [WIDTH-1:0] sr_shifted;
    logic             on_last;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign busy      = (state_q == SHIFT) || (fifo_count != '0);

    bs_byte_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign sr_shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    assign on_last    = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        fifo_pop  = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        ser_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sr_d     = fifo_data;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_data  = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
                ser_last  = on_last;
                if (ser_ready) begin
                    if (!on_last) begin
                        sr_d  = sr_shifted;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (!fifo_empty) begin
                        // Chain straight into the next queued word: no idle bubble.
                        fifo_pop = 1'b1;
                        sr_d     = fifo_data;
                        cnt_d    = '0;
                    end else begin
                        sr_d    = sr_shifted;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bs_out_serializer.sv
// Directed bench for bs_out_serializer: expected serial bits are queued on
// each accepted push and a negedge monitor compares every bit transfer.
module tb_bs_out_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ser_data;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_last;
    logic       busy;

    int n_checks;
    int n_fail;

    // Each entry is {expected ser_data, expected ser_last}.
    logic [1:0] exp_q[$];

    bs_out_serializer #(
        .WIDTH     (8),
        .DEPTH     (2),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back({w[i], (i == 0) ? 1'b1 : 1'b0});
        end
    endtask

    // Scoreboard monitor: compares every accepted serial bit in order.
    always @(negedge clk) begin
        if (!rst && ser_valid && ser_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bit", {30'd0, ser_data, ser_last}, 32'hFF);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                chk("ser_bit", {30'd0, ser_data, ser_last}, {30'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        logic acc;
        acc      = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (acc) expect_word(w);
        chk("push_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_valid"}, {31'd0, ser_valid}, 32'd0);
        chk({name, "_data"}, {31'd0, ser_data}, 32'd0);
        chk({name, "_last"}, {31'd0, ser_last}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic wait_valid();
        int t;
        for (t = 0; t < 50 && !ser_valid; t++) tick();
        chk("wait_valid", {31'd0, ser_valid}, 32'd1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && (exp_q.size() != 0 || busy); t++) tick();
        chk("drain_queue", exp_q.size(), 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic first_bit;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        ser_ready = 1'b1;

        // Reset for two cycles with a stray push that must be ignored.
        tick();
        check_idle("rst1");
        in_data  = 8'hFF;
        in_valid = 1'b1;
        tick();
        check_idle("rst2");
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_idle("post_rst");
        end

        // Single word, checking the two-edge start latency.
        push_word(8'hDC);
        chk("lat_e0_valid", {31'd0, ser_valid}, 32'd0);
        tick();
        chk("lat_e1_valid", {31'd0, ser_valid}, 32'd1);
        for (int i = 0; i < 8; i++) tick();
        chk("single_end_valid", {31'd0, ser_valid}, 32'd0);
        chk("single_end_busy", {31'd0, busy}, 32'd0);
        chk("single_queue", exp_q.size(), 32'd0);

        // Back-to-back words must stream as 16 gapless bits.
        push_word(8'hDC);
        push_word(8'h6E);
        wait_valid();
        for (int i = 0; i < 16; i++) begin
            chk("b2b_no_gap", {31'd0, ser_valid}, 32'd1);
            tick();
        end
        chk("b2b_end_valid", {31'd0, ser_valid}, 32'd0);
        wait_drain();

        // Backpressure: one word in the shifter, two in the FIFO.
        ser_ready = 1'b0;
        push_word(8'hDC);
        push_word(8'h6E);
        push_word(8'hB7);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        first_bit = ser_data;
        chk("bp_first_bit", {31'd0, first_bit}, 32'd1);
        in_data  = 8'h5A;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_held_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_data", {31'd0, ser_data}, {31'd0, first_bit});
            chk("bp_hold_last", {31'd0, ser_last}, 32'd0);
        end
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        wait_drain();

        // Push in the same cycle that the last bit pops the queued word.
        ser_ready = 1'b0;
        push_word(8'hDC);
        push_word(8'h6E);
        ser_ready = 1'b1;
        for (int t = 0; t < 50 && !ser_last; t++) tick();
        chk("pp_reached_last", {31'd0, ser_last}, 32'd1);
        chk("pp_in_ready", {31'd0, in_ready}, 32'd1);
        in_data  = 8'hB7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_word(8'hB7);
        chk("pp_seamless_valid", {31'd0, ser_valid}, 32'd1);
        chk("pp_seamless_last", {31'd0, ser_last}, 32'd0);
        chk("pp_count_one", {31'd0, in_ready}, 32'd1);
        push_word(8'h3C);
        chk("pp_count_two", {31'd0, in_ready}, 32'd0);
        wait_drain();

        // Reset after three bits of a word discards the remainder.
        ser_ready = 1'b0;
        push_word(8'hDC);
        wait_valid();
        ser_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ser_ready = 1'b0;
        rst       = 1'b1;
        exp_q.delete();
        tick();
        chk("midrst_valid", {31'd0, ser_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_last", {31'd0, ser_last}, 32'd0);
        rst       = 1'b0;
        ser_ready = 1'b1;
        tick();
        push_word(8'hB7);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
